jesd204_ext_sync_trigger: RTL
=============================

// Module: jesd204_ext_sync_trigger
// PURPOSE
// - Downstream consumer of the external-sync arming stage (sync_armed). Resynchronises the asynchronous
//   sync_in pin, detects the first qualifying edge while armed, aligns it to the next LMFC boundary plus
//   a programmable cycle offset, and emits a one-cycle trigger to the link/transport start logic.
// - After firing it requests auto-disarm from the arming stage, so one arm yields exactly one trigger.
// PARAMETERS
// - ENABLED      1   0: FSM held in IDLE; all outputs stay 0, including trigger_out.
// - SYNC_STAGES  3   Synchroniser depth on sync_in; legal range 2..4.
// - EDGE_FALLING 0   0: trigger on a rising edge of sync_in. 1: trigger on a falling edge.
// - DELAY_W      8   Width of cfg_delay.
// - CNT_W        16  Width of trigger_count.
// PORTS
// - clk              in   1        Device clock. The only clock.
// - resetn           in   1        Synchronous, active-low reset.
// - sync_in          in   1        External sync pin; asynchronous to clk.
// - sync_armed       in   1        Level from the arming stage.
// - lmfc_edge        in   1        One-cycle pulse at each LMFC/multiframe boundary.
// - cfg_delay        in   DELAY_W  Number of cycles from lmfc_edge to the trigger.
// - status_clr       in   1        One-cycle pulse that clears sync_overrun.
// - trigger_out      out  1        One-cycle start pulse.
// - ext_sync_disarm  out  1        One-cycle disarm request, asserted together with trigger_out.
// - busy             out  1        High whenever state != IDLE.
// - sync_overrun     out  1        Sticky flag: an extra sync edge arrived while a capture was pending.
// - trigger_count    out  CNT_W    Number of triggers fired; wraps modulo 2^CNT_W.
// BEHAVIOUR
// - Reset (resetn == 0 at a clk edge): every output is 0, the synchroniser flops are 0, state = IDLE.
//   Reset asserted mid-operation aborts any pending trigger with no pulse.
// - Edge detection: sync_edge is registered from the last two synchroniser stages.
//   Latency from sync_in changing to sync_edge asserting is SYNC_STAGES+1 cycles.
// - FSM (registered; all outputs are registered):
//   - IDLE:  sync_armed -> ARMED. Edges seen in IDLE are ignored.
//   - ARMED: !sync_armed -> IDLE. Otherwise sync_edge -> WAIT. If lmfc_edge arrives in the same
//            cycle as the capturing sync_edge, that boundary is NOT used.
//   - WAIT:  !sync_armed -> IDLE (abort, no pulse). On lmfc_edge, latch cnt = cfg_delay -> DLY.
//            cfg_delay is sampled only at that cycle; later changes have no effect.
//   - DLY:   !sync_armed -> IDLE (abort). cnt == 0 -> FIRE; otherwise cnt decrements.
//   - FIRE:  trigger_out = 1 and ext_sync_disarm = 1 for exactly one cycle;
//            trigger_count increments; -> DONE.
//   - DONE:  waits for !sync_armed, then -> IDLE. Prevents re-triggering while arm is still held.
// - Timing: lmfc_edge in cycle T -> trigger_out high in cycle T+2+cfg_delay.
//   cfg_delay = 0 gives T+2; maximum is T+2+(2^DELAY_W-1).
// - Abort priority: if !sync_armed and lmfc_edge occur in the same cycle, the abort wins.
// - sync_overrun is set by any sync_edge while in WAIT or DLY.
//   If the set and status_clr occur in the same cycle, the set wins.
// - ext_sync_disarm is a request only; the arming stage resolves any arm/disarm collision.
// STRUCTURE
// - Shared package jesd204_ext_sync_pkg holds:
//   - state encoding localparams IDLE/ARMED/WAIT/DLY/FIRE/DONE (3-bit);
//   - default DELAY_W and CNT_W;
//   - SYNC_STAGES legal-range constants.
// - One sub-module, jesd204_sync_in_cdc: N-stage synchroniser plus registered edge detector with
//   polarity select; output is sync_edge. The FSM, delay counter and status logic live in the top level.
// TESTING
// - Reset: hold resetn=0 with sync_in toggling -> all outputs 0, busy=0.
//   Release resetn -> outputs still 0 until the block is armed.
// - Basic: sync_armed=1, cfg_delay=5, rising edge on sync_in, lmfc_edge at cycle T
//   -> trigger_out and ext_sync_disarm high only in cycle T+7; trigger_count=1.
// - Collision: sync_edge and lmfc_edge in the same cycle, next lmfc_edge 32 cycles later at T2, cfg_delay=0
//   -> trigger at T2+2, not at the first boundary.
// - Abort: deassert sync_armed during DLY with cfg_delay=200 -> no trigger; busy=0 on the next cycle;
//   trigger_count unchanged.
// - Overrun and re-arm: extra sync edge in WAIT -> sync_overrun=1, held until status_clr.
//   Hold sync_armed=1 after FIRE -> stays in DONE with no second trigger; drop sync_armed then re-arm
//   -> second trigger, trigger_count=2.
// - Configuration: ENABLED=0 -> trigger_out never asserts under the Basic stimulus.
//   EDGE_FALLING=1 -> only falling edges capture.

Source files
------------

// File: rtl/jesd204_ext_sync_pkg.sv
// Shared types and constants for the external-sync trigger path.
package jesd204_ext_sync_pkg;

   // Trigger FSM states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DLY   = 3'd3,
      ST_FIRE  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam int unsigned DEF_DELAY_W     = 8;
   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned SYNC_STAGES_MIN = 2;
   localparam int unsigned SYNC_STAGES_MAX = 4;

   // True when a synchroniser depth is within the supported range.
   function automatic bit sync_stages_legal(int unsigned n);
      return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
   endfunction

endpackage

// File: rtl/jesd204_sync_in_cdc.sv
// Synchroniser for the asynchronous sync_in pin plus a registered edge
// detector. sync_edge rises STAGES+1 cycles after sync_in changes.
module jesd204_sync_in_cdc
   import jesd204_ext_sync_pkg::*;
#(
   parameter int unsigned STAGES       = 3,
   parameter int unsigned EDGE_FALLING = 0
) (
   input  logic clk,
   input  logic resetn,
   input  logic sync_in,
   output logic sync_edge
);

   if (!sync_stages_legal(STAGES)) begin : g_bad_stages
      $error("jesd204_sync_in_cdc: STAGES out of range");
   end

   logic [STAGES-1:0] r_sync;
   logic              r_last;
   logic              r_edge;

   // Shift the pin through the synchroniser and flag the selected edge polarity.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_sync <= '0;
         r_last <= 1'b0;
         r_edge <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], sync_in};
         r_last <= r_sync[STAGES-1];
         if (EDGE_FALLING != 0) begin
            r_edge <= ~r_sync[STAGES-1] & r_last;
         end else begin
            r_edge <= r_sync[STAGES-1] & ~r_last;
         end
      end
   end

   assign sync_edge = r_edge;

endmodule

// File: rtl/jesd204_ext_sync_trigger.sv
// External-sync trigger: captures the first qualifying sync edge while
// armed, aligns it to the next LMFC boundary plus cfg_delay cycles, fires a
// single start pulse and requests disarm.
module jesd204_ext_sync_trigger
   import jesd204_ext_sync_pkg::*;
#(
   parameter int unsigned ENABLED      = 1,
   parameter int unsigned SYNC_STAGES  = 3,
   parameter int unsigned EDGE_FALLING = 0,
   parameter int unsigned DELAY_W      = DEF_DELAY_W,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               sync_in,
   input  logic               sync_armed,
   input  logic               lmfc_edge,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic               status_clr,
   output logic               trigger_out,
   output logic               ext_sync_disarm,
   output logic               busy,
   output logic               sync_overrun,
   output logic [CNT_W-1:0]   trigger_count
);

   logic               w_sync_edge;

   state_t             r_state;
   logic [DELAY_W-1:0] r_cnt;
   logic               r_trigger;
   logic               r_disarm;
   logic               r_busy;
   logic               r_overrun;
   logic [CNT_W-1:0]   r_count;

   jesd204_sync_in_cdc #(
      .STAGES       (SYNC_STAGES),
      .EDGE_FALLING (EDGE_FALLING)
   ) u_sync_in_cdc (
      .clk       (clk),
      .resetn    (resetn),
      .sync_in   (sync_in),
      .sync_edge (w_sync_edge)
   );

   // Trigger FSM with delay counter, status flag and registered outputs.
   // busy is loaded with the next-state != IDLE so it tracks state exactly.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_trigger <= 1'b0;
         r_disarm  <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_count   <= '0;
      end else begin
         r_trigger <= 1'b0;
         r_disarm  <= 1'b0;
         if (ENABLED == 0) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_count   <= '0;
         end else begin
            // A set in the same cycle as a clear wins.
            if (w_sync_edge && (r_state == ST_WAIT || r_state == ST_DLY)) begin
               r_overrun <= 1'b1;
            end else if (status_clr) begin
               r_overrun <= 1'b0;
            end

            case (r_state)
               ST_IDLE: begin
                  if (sync_armed) begin
                     r_state <= ST_ARMED;
                     r_busy  <= 1'b1;
                  end
               end
               ST_ARMED: begin
                  if (!sync_armed) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else if (w_sync_edge) begin
                     r_state <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (!sync_armed) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else if (lmfc_edge) begin
                     r_cnt   <= cfg_delay;
                     r_state <= ST_DLY;
                  end
               end
               ST_DLY: begin
                  if (!sync_armed) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else if (r_cnt == '0) begin
                     r_state   <= ST_FIRE;
                     r_trigger <= 1'b1;
                     r_disarm  <= 1'b1;
                     r_count   <= r_count + CNT_W'(1);
                  end else begin
                     r_cnt <= r_cnt - DELAY_W'(1);
                  end
               end
               ST_FIRE: begin
                  r_state <= ST_DONE;
               end
               ST_DONE: begin
                  if (!sync_armed) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign trigger_out     = r_trigger;
   assign ext_sync_disarm = r_disarm;
   assign busy            = r_busy;
   assign sync_overrun    = r_overrun;
   assign trigger_count   = r_count;

endmodule
